fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, including the IF/ID pipeline register. It owns the PC and drives a req/ack instruction-memory handshake, which may have variable latency. It applies stallF/stallD from the hazard unit and redirects on branch/jump resolved in decode. Taken redirects are not delay-slotted: the wrong-path fetch is discarded and a bubble enters decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID as a bubble

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stallF  in  1  hazard unit: hold PC/fetch FSM
stallD  in  1  hazard unit: hold IF/ID register (always equal to stallF; unequal is illegal)
pcsrcD  in  1  branch taken in decode
pcbranchD  in  32  branch target
jumpD  in  1  jump in decode
pcjumpD  in  32  jump target
inst_req  out  1  fetch request to instruction memory
inst_addr  out  32  fetch address (= pcF)
inst_ack  in  1  one-cycle pulse: inst_rdata valid for inst_addr
inst_rdata  in  32  fetched word
pcF  out  32  current fetch PC
instrD  out  32  IF/ID instruction
pcplus4D  out  32  IF/ID PC+4
validD  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (rst=1 at an edge): pcF=RESET_PC, state=REQ, instrD=NOP_INSTR, pcplus4D=0, validD=0, buffer cleared. inst_req=0 while rst is high. Reset mid-handshake abandons the request; memory shares rst.
- redirect = (pcsrcD | jumpD) & ~stallD. Target = pcbranchD if pcsrcD, else pcjumpD (pcsrcD has priority).
- Handshake: inst_req/inst_addr are held stable until inst_ack. ack is valid only while inst_req=1. A new address may be presented the cycle after ack, so memory may ack every cycle.
- Bubble load: instrD=NOP_INSTR, validD=0, pcplus4D unchanged.
- State REQ (inst_req=1, inst_addr=pcF):
  - redirect & ack: drop rdata; pcF<=target; stay REQ; bubble into IF/ID.
  - redirect & ~ack: pend_pc<=target; go to DRAIN; bubble.
  - ~redirect & ack & ~stallF: instrD<=inst_rdata, pcplus4D<=pcF+4, validD<=1; pcF<=pcF+4; stay REQ (zero-bubble streaming).
  - ~redirect & ack & stallF: buf<=inst_rdata; go to HAVE; IF/ID held.
  - ~ack: if ~stallD, bubble; else hold.
- State HAVE (inst_req=0; the word for pcF is in buf):
  - redirect: pcF<=target; go to REQ; bubble.
  - ~stallF: IF/ID<={buf, pcF+4, 1}; pcF<=pcF+4; go to REQ.
  - stallF: hold everything.
- State DRAIN (inst_req=1, inst_addr=old pcF; wrong-path request outstanding):
  - ack: drop rdata; pcF<=pend_pc; go to REQ.
  - Any redirect overwrites pend_pc; if it coincides with ack, the new target is used.
  - IF/ID takes a bubble if ~stallD, else holds.
- Stalls never reorder or drop a correct-path word; each acked correct-path word enters IF/ID exactly once.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0. Targets are used unaligned-as-given (alignment is checked elsewhere).
- Latency: first valid instrD one cycle after the first ack following reset.

Decomposition:
- Shared pipeline package: FSM state enum (REQ, HAVE, DRAIN), RESET_PC default, NOP_INSTR constant.
- One natural sub-module: if_id_reg (enable + synchronous clear flop holding instrD/pcplus4D/validD), reused later for ID/EX.

Test Plan:
- Reset, then ack every cycle with rdata=addr^32'hA5A5_0000 -> inst_addr 0,4,8,...; instrD A5A5_0000,A5A5_0004,...; pcplus4D 4,8,...; validD=1 continuously from cycle after first ack.
- Ack latency 3 cycles -> inst_addr held 3 cycles; validD=0 bubbles between valid words; no word duplicated.
- stallF=stallD=1 on ack cycle of pc 0x8 for 2 cycles -> inst_req=0, instrD held; on release, instrD=word(0x8), next inst_addr 0xC.
- pcsrcD=1, pcbranchD=0x100 while req for 0x10 outstanding, ack 2 cycles later -> rdata dropped, validD=0, next inst_addr 0x100.
- pcsrcD and jumpD together with ack in same cycle -> next inst_addr=pcbranchD, bubble; pcsrcD during stallD=1 -> ignored.
- rst asserted in DRAIN -> next cycle pcF=RESET_PC, validD=0, inst_req=0 during rst, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage and the pipeline
//   registers that follow it: fetch FSM state encoding, default reset PC,
//   default bubble instruction and a small PC arithmetic helper.
package fetch_stage_pkg;

  // Fetch FSM states:
  //   ST_REQ   - request for pcF outstanding on the instruction bus
  //   ST_HAVE  - word for pcF captured in the side buffer during a stall
  //   ST_DRAIN - wrong-path request still outstanding after a redirect
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HAVE  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Sequential PC step; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Instruction-memory request/acknowledge bus.
//   inst_req   : fetch request (master -> slave), held until inst_ack
//   inst_addr  : fetch address, stable while inst_req is high
//   inst_ack   : one-cycle pulse, inst_rdata valid for inst_addr
//   inst_rdata : fetched instruction word
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ack,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ack,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg
//   Pipeline register holding {instr, pcplus4, valid} between two stages.
//   clk/rst      : clock, synchronous active-high reset
//   en           : load instr_in/pcplus4_in/valid_in
//   clr          : insert a bubble (instr=NOP_INSTR, valid=0, pcplus4 kept);
//                  takes priority over en
//   instr_out, pcplus4_out, valid_out : registered contents
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_in,
  input  logic [31:0] pcplus4_in,
  input  logic        valid_in,
  output logic [31:0] instr_out,
  output logic [31:0] pcplus4_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  // Next-value selection: bubble, load or hold.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (clr) begin
      // A bubble keeps pcplus4 so the register still reflects the last PC.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d   = instr_in;
      pcplus4_d = pcplus4_in;
      valid_d   = valid_in;
    end else begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_out   = instr_q;
  assign pcplus4_out = pcplus4_q;
  assign valid_out   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage with IF/ID pipeline register. Owns the PC,
//   drives a variable-latency req/ack instruction bus, honours hazard
//   stalls and redirects from decode. Redirects are not delay-slotted:
//   any wrong-path word is dropped and a bubble enters decode.
//   clk, rst          : clock, synchronous active-high reset
//   stallF, stallD    : hazard stalls (always driven equal)
//   pcsrcD, pcbranchD : taken branch and its target (priority over jump)
//   jumpD, pcjumpD    : jump and its target
//   imem              : instruction bus master (req/addr/ack/rdata)
//   pcF               : current fetch PC
//   instrD, pcplus4D, validD : IF/ID register contents
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallF,
  input  logic                 stallD,
  input  logic                 pcsrcD,
  input  logic [31:0]          pcbranchD,
  input  logic                 jumpD,
  input  logic [31:0]          pcjumpD,
  fetch_stage_if.master        imem,
  output logic [31:0]          pcF,
  output logic [31:0]          instrD,
  output logic [31:0]          pcplus4D,
  output logic                 validD
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  word_buf_q, word_buf_d;

  logic         req_s;
  logic         ack_s;
  logic         redirect_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_plus4_s;

  logic         ifid_en_s;
  logic         ifid_clr_s;
  logic [31:0]  ifid_instr_s;

  // The bus is idle only while the word sits in the side buffer, and is
  // forced low during reset so an abandoned request is not re-issued.
  assign req_s          = ~rst & (state_q != ST_HAVE);
  assign imem.inst_req  = req_s;
  assign imem.inst_addr = pc_q;

  // An ack outside a request is ignored.
  assign ack_s      = imem.inst_ack & req_s;
  assign redirect_s = (pcsrcD | jumpD) & ~stallD;
  assign target_s   = pcsrcD ? pcbranchD : pcjumpD;
  assign pc_plus4_s = pc_plus4(pc_q);

  // Fetch FSM next-state, PC update and IF/ID control.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    word_buf_d   = word_buf_q;
    ifid_en_s    = 1'b0;
    ifid_clr_s   = 1'b0;
    ifid_instr_s = imem.inst_rdata;

    case (state_q)
      ST_REQ: begin
        if (redirect_s) begin
          ifid_clr_s = 1'b1;
          if (ack_s) begin
            // Wrong-path word arrived together with the redirect: drop it.
            pc_d    = target_s;
            state_d = ST_REQ;
          end else begin
            // Request cannot be withdrawn; wait for its ack in DRAIN.
            pend_d  = target_s;
            state_d = ST_DRAIN;
          end
        end else if (ack_s) begin
          if (stallF) begin
            // Park the word until decode can accept it.
            word_buf_d = imem.inst_rdata;
            state_d    = ST_HAVE;
          end else begin
            ifid_en_s    = 1'b1;
            ifid_instr_s = imem.inst_rdata;
            pc_d         = pc_plus4_s;
            state_d      = ST_REQ;
          end
        end else begin
          ifid_clr_s = ~stallD;
          state_d    = ST_REQ;
        end
      end

      ST_HAVE: begin
        if (redirect_s) begin
          ifid_clr_s = 1'b1;
          pc_d       = target_s;
          state_d    = ST_REQ;
        end else if (~stallF) begin
          ifid_en_s    = 1'b1;
          ifid_instr_s = word_buf_q;
          pc_d         = pc_plus4_s;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_HAVE;
        end
      end

      ST_DRAIN: begin
        ifid_clr_s = ~stallD;
        if (redirect_s) begin
          pend_d = target_s;
        end else begin
          pend_d = pend_q;
        end
        if (ack_s) begin
          // A redirect in the ack cycle wins over the older pending target.
          pc_d    = redirect_s ? target_s : pend_q;
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        ifid_clr_s = 1'b1;
        state_d    = ST_REQ;
      end
    endcase
  end

  // Fetch state, PC, pending target and side buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      pend_q     <= 32'h0000_0000;
      word_buf_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      word_buf_q <= word_buf_d;
    end
  end

  assign pcF = pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .en          (ifid_en_s),
    .clr         (ifid_clr_s),
    .instr_in    (ifid_instr_s),
    .pcplus4_in  (pc_plus4_s),
    .valid_in    (1'b1),
    .instr_out   (instrD),
    .pcplus4_out (pcplus4D),
    .valid_out   (validD)
  );

endmodule
